// File: rtl/decode_read_pkg.sv
// decode_read_pkg
//   Shared definitions for the decode/register-read stage: the 7-bit
//   opcode encoding, the decode FSM states, the register-index width and
//   the per-opcode table of which source fields an instruction reads.
package decode_read_pkg;

    localparam int REG_IDX_W = 3;
    localparam int NUM_REGS  = 8;
    localparam int OP_W      = 7;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 7'h00,
        OP_ADD   = 7'h01,
        OP_SUB   = 7'h02,
        OP_AND   = 7'h03,
        OP_OR    = 7'h04,
        OP_XOR   = 7'h05,
        OP_LOAD  = 7'h10,
        OP_STORE = 7'h11,
        OP_LI    = 7'h12,
        OP_JMP   = 7'h20,
        OP_HALT  = 7'h7F
    } opcode_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HAZARD,
        ST_HALTED
    } state_e;

    typedef struct packed {
        logic known;
        logic src1;
        logic src2;
    } op_info_t;

    // Immediate-form opcodes (LI) overlay imm6 on the source fields, so
    // they must not report source usage or they would raise false hazards.
    function automatic op_info_t uses_src(input logic [OP_W-1:0] op);
        op_info_t info;
        info = '0;
        case (op)
            OP_NOP, OP_HALT, OP_LI: begin
                info.known = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_STORE: begin
                info.known = 1'b1;
                info.src1  = 1'b1;
                info.src2  = 1'b1;
            end
            OP_LOAD, OP_JMP: begin
                info.known = 1'b1;
                info.src1  = 1'b1;
            end
            default: info = '0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/decode_read_regfile.sv
// decode_read_regfile
//   8 x D_SIZE register file: two combinational read ports with
//   write-through bypass, one synchronous write port.
//   Ports: clk, reset (async active-low, clears all registers),
//          wr_en/wr_idx/wr_data (write port),
//          rd_idx_a/rd_data_a, rd_idx_b/rd_data_b (read ports).
module decode_read_regfile
    import decode_read_pkg::*;
#(
    parameter int D_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_idx,
    input  logic [D_SIZE-1:0]    wr_data,
    input  logic [REG_IDX_W-1:0] rd_idx_a,
    output logic [D_SIZE-1:0]    rd_data_a,
    input  logic [REG_IDX_W-1:0] rd_idx_b,
    output logic [D_SIZE-1:0]    rd_data_b
);

    logic [D_SIZE-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_idx] <= wr_data;
        end
    end

    // Writeback data is forwarded in the same cycle it is written so the
    // decoder never sees a stale value for a register being retired.
    assign rd_data_a = (wr_en && (wr_idx == rd_idx_a)) ? wr_data : regs[rd_idx_a];
    assign rd_data_b = (wr_en && (wr_idx == rd_idx_b)) ? wr_data : regs[rd_idx_b];

endmodule

// File: rtl/decode_read.sv
// decode_read
//   Decode / register-read pipeline stage. Splits the 16-bit instruction,
//   reads operands, detects load-use hazards against the execute stage and
//   registers the decoded instruction for execute.
//   Ports: clk, reset (async active-low)
//          ir, pc_in                 instruction and its PC from fetch
//          flush                     taken branch in execute, kills decode
//          ex_load, ex_dest          execute-stage load and its destination
//          wb_en, wb_dest, wb_data   register-file write port
//          stall                     hold request to fetch
//          valid_q, op_q, dest_q, src1_q, src2_q, op1_q, op2_q, imm_q, pc_q
//                                    registered decoded instruction
module decode_read
    import decode_read_pkg::*;
#(
    parameter int A_SIZE = 10,
    parameter int D_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          ir,
    input  logic [A_SIZE-1:0]    pc_in,
    input  logic                 flush,
    input  logic                 ex_load,
    input  logic [REG_IDX_W-1:0] ex_dest,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_dest,
    input  logic [D_SIZE-1:0]    wb_data,
    output logic                 stall,
    output logic                 valid_q,
    output logic [OP_W-1:0]      op_q,
    output logic [REG_IDX_W-1:0] dest_q,
    output logic [REG_IDX_W-1:0] src1_q,
    output logic [REG_IDX_W-1:0] src2_q,
    output logic [D_SIZE-1:0]    op1_q,
    output logic [D_SIZE-1:0]    op2_q,
    output logic [D_SIZE-1:0]    imm_q,
    output logic [A_SIZE-1:0]    pc_q
);

    function automatic logic [D_SIZE-1:0] sext_imm(input logic signed [5:0] v);
        logic signed [D_SIZE-1:0] w;
        w = D_SIZE'(v);
        return w;
    endfunction

    logic [OP_W-1:0]      op_f;
    logic [REG_IDX_W-1:0] dest_f;
    logic [REG_IDX_W-1:0] src1_f;
    logic [REG_IDX_W-1:0] src2_f;
    logic signed [5:0]    imm6_f;
    logic [D_SIZE-1:0]    rd_a;
    logic [D_SIZE-1:0]    rd_b;
    op_info_t             info;
    logic                 hazard;
    logic                 issue;
    state_e               state;
    state_e               next_state;

    assign op_f   = ir[15:9];
    assign dest_f = ir[8:6];
    assign src1_f = ir[5:3];
    assign src2_f = ir[2:0];
    assign imm6_f = ir[5:0];
    assign info   = uses_src(op_f);

    assign hazard = ex_load && ((info.src1 && (ex_dest == src1_f)) ||
                                (info.src2 && (ex_dest == src2_f)));

    decode_read_regfile #(
        .D_SIZE (D_SIZE)
    ) regfile (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wb_en),
        .wr_idx    (wb_dest),
        .wr_data   (wb_data),
        .rd_idx_a  (src1_f),
        .rd_data_a (rd_a),
        .rd_idx_b  (src2_f),
        .rd_data_b (rd_b)
    );

    // HAZARD behaves like RUN: the held instruction is re-decoded with
    // fresh operands, and a repeated hazard keeps fetch held another cycle.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        issue      = 1'b0;
        if (flush) begin
            next_state = ST_RUN;
        end else begin
            case (state)
                ST_RUN, ST_HAZARD: begin
                    if (hazard) begin
                        stall      = 1'b1;
                        next_state = ST_HAZARD;
                    end else begin
                        issue      = 1'b1;
                        next_state = (op_f == OP_HALT) ? ST_HALTED : ST_RUN;
                    end
                end
                ST_HALTED: begin
                    stall = 1'b1;
                end
                default: begin
                    next_state = ST_RUN;
                end
            endcase
        end
        // Fetch must never be held while the pipeline is in reset.
        if (!reset) begin
            stall = 1'b0;
        end
    end

    // Stage boundary: decode -> execute pipeline register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_RUN;
            valid_q <= 1'b0;
            op_q    <= OP_NOP;
            dest_q  <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
        end else begin
            state <= next_state;
            if (issue && info.known) begin
                valid_q <= 1'b1;
                op_q    <= op_f;
                dest_q  <= dest_f;
                src1_q  <= src1_f;
                src2_q  <= src2_f;
                op1_q   <= rd_a;
                op2_q   <= rd_b;
                imm_q   <= sext_imm(imm6_f);
                pc_q    <= pc_in;
            end else begin
                // Bubble: hazard, flush, HALTED, or an unknown opcode.
                valid_q <= 1'b0;
                op_q    <= OP_NOP;
                dest_q  <= '0;
                src1_q  <= '0;
                src2_q  <= '0;
                op1_q   <= '0;
                op2_q   <= '0;
                imm_q   <= '0;
                pc_q    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_decode_read.sv
// tb_decode_read
//   Directed bench for decode_read. Expected outputs are computed from the
//   instruction fields and a reference copy of the register file, queued
//   when the step is driven and compared one clock later.
module tb_decode_read;
    import decode_read_pkg::*;

    localparam int A_SIZE = 10;
    localparam int D_SIZE = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [15:0]       ir;
    logic [A_SIZE-1:0] pc_in;
    logic              flush;
    logic              ex_load;
    logic [2:0]        ex_dest;
    logic              wb_en;
    logic [2:0]        wb_dest;
    logic [D_SIZE-1:0] wb_data;
    logic              stall;
    logic              valid_q;
    logic [6:0]        op_q;
    logic [2:0]        dest_q;
    logic [2:0]        src1_q;
    logic [2:0]        src2_q;
    logic [D_SIZE-1:0] op1_q;
    logic [D_SIZE-1:0] op2_q;
    logic [D_SIZE-1:0] imm_q;
    logic [A_SIZE-1:0] pc_q;

    always #5 clk = ~clk;

    decode_read #(
        .A_SIZE (A_SIZE),
        .D_SIZE (D_SIZE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ir      (ir),
        .pc_in   (pc_in),
        .flush   (flush),
        .ex_load (ex_load),
        .ex_dest (ex_dest),
        .wb_en   (wb_en),
        .wb_dest (wb_dest),
        .wb_data (wb_data),
        .stall   (stall),
        .valid_q (valid_q),
        .op_q    (op_q),
        .dest_q  (dest_q),
        .src1_q  (src1_q),
        .src2_q  (src2_q),
        .op1_q   (op1_q),
        .op2_q   (op2_q),
        .imm_q   (imm_q),
        .pc_q    (pc_q)
    );

    typedef struct {
        logic              valid;
        logic [6:0]        op;
        logic [2:0]        dest;
        logic [2:0]        src1;
        logic [2:0]        src2;
        logic [D_SIZE-1:0] op1;
        logic [D_SIZE-1:0] op2;
        logic [D_SIZE-1:0] imm;
        logic [A_SIZE-1:0] pc;
    } exp_t;

    exp_t              sb[$];
    logic [D_SIZE-1:0] ref_rf [8];
    int                checks = 0;
    int                errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [D_SIZE-1:0] rd_ref(input logic [2:0] idx);
        return (wb_en && wb_dest == idx) ? wb_data : ref_rf[idx];
    endfunction

    function automatic exp_t dec_exp();
        exp_t e;
        e.valid = 1'b1;
        e.op    = ir[15:9];
        e.dest  = ir[8:6];
        e.src1  = ir[5:3];
        e.src2  = ir[2:0];
        e.op1   = rd_ref(ir[5:3]);
        e.op2   = rd_ref(ir[2:0]);
        e.imm   = {{(D_SIZE-6){ir[5]}}, ir[5:0]};
        e.pc    = pc_in;
        return e;
    endfunction

    function automatic exp_t bubble();
        exp_t e;
        e.valid = 1'b0;
        e.op    = 7'h00;
        e.dest  = '0;
        e.src1  = '0;
        e.src2  = '0;
        e.op1   = '0;
        e.op2   = '0;
        e.imm   = '0;
        e.pc    = '0;
        return e;
    endfunction

    task automatic check_out(input string tag, input exp_t e);
        chk({tag, ".valid"}, 64'(valid_q), 64'(e.valid));
        chk({tag, ".op"},    64'(op_q),    64'(e.op));
        chk({tag, ".dest"},  64'(dest_q),  64'(e.dest));
        chk({tag, ".src1"},  64'(src1_q),  64'(e.src1));
        chk({tag, ".src2"},  64'(src2_q),  64'(e.src2));
        chk({tag, ".op1"},   64'(op1_q),   64'(e.op1));
        chk({tag, ".op2"},   64'(op2_q),   64'(e.op2));
        chk({tag, ".imm"},   64'(imm_q),   64'(e.imm));
        chk({tag, ".pc"},    64'(pc_q),    64'(e.pc));
    endtask

    // One pipeline cycle: check stall combinationally, queue the expected
    // registered result, clock, then pop and compare.
    task automatic step(input string tag, input bit expect_issue, input logic exp_stall);
        exp_t e;
        #1;
        chk({tag, ".stall"}, 64'(stall), 64'(exp_stall));
        sb.push_back(expect_issue ? dec_exp() : bubble());
        @(posedge clk);
        if (wb_en) ref_rf[wb_dest] = wb_data;
        #1;
        e = sb.pop_front();
        check_out(tag, e);
    endtask

    task automatic set_ir(input logic [15:0] i, input logic [A_SIZE-1:0] p);
        ir    = i;
        pc_in = p;
    endtask

    task automatic set_wb(input logic en, input logic [2:0] d, input logic [D_SIZE-1:0] v);
        wb_en   = en;
        wb_dest = d;
        wb_data = v;
    endtask

    task automatic set_ex(input logic ld, input logic [2:0] d);
        ex_load = ld;
        ex_dest = d;
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        set_ir(16'h0000, '0);
        set_ex(1'b0, 3'd0);
        set_wb(1'b0, 3'd0, '0);
        for (int i = 0; i < 8; i++) ref_rf[i] = '0;

        // Reset state, with inputs that would otherwise form a hazard.
        #2;
        check_out("reset", bubble());
        set_ir({OP_ADD, 3'd1, 3'd0, 3'd0}, 10'd0);
        set_ex(1'b1, 3'd0);
        #1;
        chk("reset.stall", 64'(stall), 64'd0);
        set_ex(1'b0, 3'd0);
        set_ir(16'h0000, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        set_wb(1'b1, 3'd1, 32'd5);
        set_ir({OP_NOP, 9'd0}, 10'd1);
        step("nop", 1'b1, 1'b0);

        // ADD r3,r1,r2 with r1=5 and r2=7 (r2 arriving via bypass).
        set_wb(1'b1, 3'd2, 32'd7);
        set_ir({OP_ADD, 3'd3, 3'd1, 3'd2}, 10'd2);
        step("add", 1'b1, 1'b0);

        set_wb(1'b1, 3'd1, 32'hDEAD);
        set_ir({OP_SUB, 3'd4, 3'd1, 3'd2}, 10'd3);
        step("bypass", 1'b1, 1'b0);

        set_wb(1'b0, 3'd0, '0);
        set_ir({OP_LI, 3'd5, 6'b111110}, 10'd4);
        step("imm_neg", 1'b1, 1'b0);

        // Load-use hazard on r2, repeated once, then resolved with new r2.
        set_ex(1'b1, 3'd2);
        set_ir({OP_ADD, 3'd6, 3'd1, 3'd2}, 10'd5);
        step("haz1", 1'b0, 1'b1);
        step("haz2", 1'b0, 1'b1);
        set_ex(1'b0, 3'd0);
        set_wb(1'b1, 3'd2, 32'd99);
        step("haz_res", 1'b1, 1'b0);

        set_wb(1'b0, 3'd0, '0);
        set_ir({7'h55, 9'h1FF}, 10'd6);
        step("unknown", 1'b0, 1'b0);

        // LOAD reads only src1; a load into its src2 field is not a hazard.
        set_ex(1'b1, 3'd2);
        set_ir({OP_LOAD, 3'd1, 3'd3, 3'd2}, 10'd7);
        step("load_nohaz", 1'b1, 1'b0);
        set_ex(1'b0, 3'd0);

        set_ir({OP_HALT, 9'd0}, 10'd8);
        step("halt", 1'b1, 1'b0);
        set_ir({OP_ADD, 3'd7, 3'd3, 3'd3}, 10'd9);
        set_wb(1'b1, 3'd3, 32'h1234);
        step("halted1", 1'b0, 1'b1);
        set_wb(1'b0, 3'd0, '0);
        step("halted2", 1'b0, 1'b1);
        flush = 1'b1;
        step("flush_halt", 1'b0, 1'b0);
        flush = 1'b0;
        step("after_halt", 1'b1, 1'b0);

        // Flush and hazard together: flush wins, no stall.
        set_ex(1'b1, 3'd1);
        set_ir({OP_ADD, 3'd2, 3'd1, 3'd0}, 10'd10);
        flush = 1'b1;
        step("flush_haz", 1'b0, 1'b0);
        flush = 1'b0;
        set_ex(1'b0, 3'd0);
        step("post_flush", 1'b1, 1'b0);

        // Reset asserted mid-stall after a valid decode.
        set_ir({OP_ADD, 3'd6, 3'd1, 3'd2}, 10'd11);
        step("pre_reset", 1'b1, 1'b0);
        set_ex(1'b1, 3'd1);
        #1;
        chk("midstall.stall", 64'(stall), 64'd1);
        reset = 1'b0;
        #1;
        check_out("async_reset", bubble());
        chk("async_reset.stall", 64'(stall), 64'd0);
        for (int i = 0; i < 8; i++) ref_rf[i] = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        set_ex(1'b0, 3'd0);
        step("post_reset", 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_read.md
DECODE_READ -- requirements
Module: decode_read

Interface
REQ-001 Parameter A_SIZE, default 10, program-counter width.
REQ-002 Parameter D_SIZE, default 32, data/register width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ir  input  16  instruction from fetch stage.
REQ-006 pc_in  input  A_SIZE  PC associated with ir.
REQ-007 flush  input  1  taken branch/jump in execute (same cycle fetch sees load_pc_flag).
REQ-008 ex_load  input  1  execute stage currently holds a LOAD.
REQ-009 ex_dest  input  3  destination register of execute-stage instruction.
REQ-010 wb_en, wb_dest, wb_data  input  1/3/D_SIZE  register-file write port from writeback.
REQ-011 stall  output  1  hold request to fetch stage.
REQ-012 valid_q, op_q, dest_q, src1_q, src2_q  output  1/7/3/3/3  registered decoded fields.
REQ-013 op1_q, op2_q, imm_q  output  D_SIZE each  registered operands and sign-extended immediate.
REQ-014 pc_q  output  A_SIZE  registered PC.

Function
REQ-015 Field split: op=ir[15:9], dest=ir[8:6], src1=ir[5:3], src2=ir[2:0], imm6=ir[5:0].
REQ-016 imm_q = imm6 sign-extended to D_SIZE.
REQ-017 Register file: 8 x D_SIZE, two combinational read ports, one synchronous write port.
REQ-018 Read bypass: wb_en and wb_dest equal to a read index -> that port returns wb_data same cycle.
REQ-019 uses_src1/uses_src2 come from the per-opcode table; NOP and HALT use neither.
REQ-020 Load-use hazard = ex_load and ((uses_src1 and ex_dest==src1) or (uses_src2 and ex_dest==src2)).
REQ-021 FSM states RUN, HAZARD, HALTED.
REQ-022 RUN, no hazard, not HALT: register decoded instruction, valid_q=1, one-cycle latency ir -> *_q.
REQ-023 RUN, hazard: stall=1 combinationally, register bubble (op_q=NOP, valid_q=0), go HAZARD.
REQ-024 HAZARD: stall=0, re-decode held ir with fresh operands, return RUN; hazard again -> stay HAZARD.
REQ-025 RUN, op==HALT: issue HALT with valid_q=1, go HALTED.
REQ-026 HALTED: stall=1, bubbles only; leave only via flush or reset.
REQ-027 flush has priority over hazard/HALT in every state: register bubble, stall=0, next state RUN.
REQ-028 Unknown opcodes decode as NOP with valid_q=0.
REQ-029 Register-file write occurs in every state, including HALTED and flush cycles.

Reset
REQ-030 reset low -> state RUN, valid_q=0, op_q=NOP, dest_q/src1_q/src2_q=0, op1_q/op2_q/imm_q=0, pc_q=0.
REQ-031 reset low -> all 8 registers cleared to 0; stall=0 while in reset.
REQ-032 Reset asserted mid-stall or in HALTED discards state immediately, asynchronously.

Structure
REQ-033 Shared package holds opcode enum (7-bit), FSM state enum, register-index width constant, uses_src table function.
REQ-034 Register file is one sub-module, regfile, instantiated once.
REQ-035 Pipeline register, FSM and hazard logic live in decode_read.

Verification
REQ-036 Reset release, ir=ADD r3,r1,r2 with r1=5,r2=7 -> next edge valid_q=1, dest_q=3, op1_q=5, op2_q=7.
REQ-037 ex_load=1, ex_dest=2, ir reads r2 -> stall=1 that cycle, bubble registered, then decode with new r2 next cycle.
REQ-038 wb_en=1, wb_dest=1, wb_data=0xDEAD, ir reads r1 -> op1_q=0xDEAD same edge.
REQ-039 ir imm6=6'b111110 -> imm_q=0xFFFFFFFE.
REQ-040 HALT decoded -> valid_q=1 once, stall held 1; flush=1 -> bubble, stall=0, RUN.
REQ-041 flush and hazard same cycle -> bubble, stall=0; reset mid-HAZARD -> all outputs zero, state RUN.
